// File: rtl/rv32_pkg.sv
// Shared types for the RV32 core slice.
//   arb_state_t : states of the unified-memory port arbiter
//   grant_t     : which requester owned the most recent memory grant
//   XLEN        : native word width; default for address and data buses
package rv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch
// (IF) and load/store (MEM). One requester owns the bus at a time; the
// transaction is held until mem_ready, then the response is returned with a
// one-cycle valid pulse. A branch flush cannot abort a fetch already on the
// bus, so the fetch is marked killed and its valid pulse is suppressed.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | bus free; pick an eligible requester
// ARB_FETCH | instruction read on the bus, waiting for mem_ready
// ARB_DATA  | load/store on the bus, waiting for mem_ready
//
// Ports
//   clk, rst                 clock, async active-high reset
//   if_req/if_addr           fetch request and PC, held until if_valid
//   if_rdata/if_valid        fetched instruction and its one-cycle valid
//   flush                    branch taken; cancel the outstanding fetch
//   dm_rd/dm_wr/dm_addr/
//   dm_wdata                 load/store request, held until dm_valid
//   dm_rdata/dm_valid        load data / store done, one-cycle valid
//   mem_req/mem_we/mem_addr/
//   mem_wdata                registered memory command
//   mem_rdata/mem_ready      memory response
//   stall_if/stall_mem       pipeline stalls, combinational
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              flush,

    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        r_state,        w_state_nxt;
    grant_t            r_last_grant,   w_last_grant_nxt;
    logic              r_fetch_kill,   w_fetch_kill_nxt;
    logic              r_mem_req,      w_mem_req_nxt;
    logic              r_mem_we,       w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,     w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata,    w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,     w_if_rdata_nxt;
    logic              r_if_valid,     w_if_valid_nxt;
    logic [DATA_W-1:0] r_dm_rdata,     w_dm_rdata_nxt;
    logic              r_dm_valid,     w_dm_valid_nxt;

    logic              w_dm_any;
    logic              w_if_elig;
    logic              w_dm_elig;

    assign w_dm_any  = dm_rd | dm_wr;

    // A requester whose response is being delivered this cycle still holds
    // its request; masking it here prevents a spurious re-issue.
    assign w_if_elig = if_req   & ~r_if_valid;
    assign w_dm_elig = w_dm_any & ~r_dm_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_FETCH;
            r_fetch_kill <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_if_valid   <= 1'b0;
            r_dm_rdata   <= '0;
            r_dm_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_fetch_kill <= w_fetch_kill_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_dm_valid   <= w_dm_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_fetch_kill_nxt = r_fetch_kill;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_if_rdata_nxt   = r_if_rdata;
        w_if_valid_nxt   = 1'b0;
        w_dm_rdata_nxt   = r_dm_rdata;
        w_dm_valid_nxt   = 1'b0;

        unique case (r_state)
            ARB_IDLE: begin
                // Data normally wins; after a data grant the fetch side gets
                // the next turn so a load/store stream cannot starve IF.
                if (w_dm_elig && (!w_if_elig || r_last_grant == GRANT_FETCH)) begin
                    w_state_nxt      = ARB_DATA;
                    w_last_grant_nxt = GRANT_DATA;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = dm_wr;
                    w_mem_addr_nxt   = dm_addr;
                    w_mem_wdata_nxt  = dm_wdata;
                end else if (w_if_elig) begin
                    w_state_nxt      = ARB_FETCH;
                    w_last_grant_nxt = GRANT_FETCH;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = if_addr;
                end
            end

            ARB_FETCH: begin
                if (mem_ready) begin
                    w_state_nxt      = ARB_IDLE;
                    w_mem_req_nxt    = 1'b0;
                    w_if_rdata_nxt   = mem_rdata;
                    // A flush in the completing cycle kills the fetch too.
                    w_if_valid_nxt   = ~(r_fetch_kill | flush);
                    w_fetch_kill_nxt = 1'b0;
                end else if (flush) begin
                    w_fetch_kill_nxt = 1'b1;
                end
            end

            ARB_DATA: begin
                if (mem_ready) begin
                    w_state_nxt    = ARB_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_dm_valid_nxt = 1'b1;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                end
            end

            default: begin
                w_state_nxt   = ARB_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;

    assign stall_if  = if_req   & ~r_if_valid;
    assign stall_mem = w_dm_any & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// IF/MEM traffic against a memory with random wait states. A cycle monitor
// checks every cycle against rules of the arbitration protocol.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, flush, dm_rd, dm_wr, mem_ready;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] dm_wdata, mem_rdata, if_rdata, dm_rdata, mem_wdata;
    logic          if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .flush     (flush),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [31:0] mem_arr [0:63];

    function automatic logic [5:0] widx(input logic [31:0] a);
        return a[7:2];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        return a;
    endfunction

    // ---------------- memory responder ----------------
    int wait_fix  = -1;
    int wait_left = 0;
    bit in_txn    = 1'b0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr[widx(mem_addr)];
                    in_txn    = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                in_txn    = 1'b0;
            end
        end
    end

    // ---------------- protocol monitor / reference model ----------------
    bit          mon_en = 1'b0;
    bit          p_mem_req = 0, p_mem_ready = 0, p_mem_we = 0;
    logic [31:0] p_mem_addr = '0, p_mem_wdata = '0;
    bit          p_if_elig = 0, p_dm_elig = 0, p_dm_wr = 0;
    logic [31:0] p_if_addr = '0, p_dm_addr = '0, p_dm_wdata = '0;
    bit          p_if_valid = 0, p_dm_valid = 0;
    bit          last_data = 0, owner_data = 0, killed = 0;
    bit          exp_if_valid = 0, exp_dm_valid = 0, exp_req, win_data;
    logic [31:0] exp_if_data = '0, exp_dm_data = '0;

    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            // no checking before the first clock edge
        end else if (rst) begin
            check_eq("rst_mem_req",   mem_req,   1'b0);
            check_eq("rst_mem_we",    mem_we,    1'b0);
            check_eq("rst_if_valid",  if_valid,  1'b0);
            check_eq("rst_dm_valid",  dm_valid,  1'b0);
            check_eq("rst_mem_addr",  mem_addr,  32'h0);
            check_eq("rst_mem_wdata", mem_wdata, 32'h0);
            check_eq("rst_if_rdata",  if_rdata,  32'h0);
            check_eq("rst_dm_rdata",  dm_rdata,  32'h0);
            exp_if_valid = 0; exp_dm_valid = 0;
            exp_if_data  = '0; exp_dm_data = '0;
            last_data = 0; owner_data = 0; killed = 0;
            p_mem_req = 0; p_mem_ready = 0; p_if_elig = 0; p_dm_elig = 0;
            p_if_valid = 0; p_dm_valid = 0;
        end else begin
            check_eq("if_valid",  if_valid, exp_if_valid);
            check_eq("dm_valid",  dm_valid, exp_dm_valid);
            check_eq("if_rdata",  if_rdata, exp_if_data);
            check_eq("dm_rdata",  dm_rdata, exp_dm_data);
            check_eq("stall_if",  stall_if,  if_req & ~if_valid);
            check_eq("stall_mem", stall_mem, (dm_rd | dm_wr) & ~dm_valid);

            // Bus busy until the cycle after mem_ready; a free bus is taken
            // in the cycle after any requester was eligible.
            exp_req = p_mem_req ? !p_mem_ready : (p_if_elig | p_dm_elig);
            check_eq("mem_req", mem_req, exp_req);

            if (p_mem_req && !p_mem_ready) begin
                check_eq("hold_addr",  mem_addr,  p_mem_addr);
                check_eq("hold_we",    mem_we,    p_mem_we);
                check_eq("hold_wdata", mem_wdata, p_mem_wdata);
            end else if (!p_mem_req && mem_req) begin
                win_data = p_dm_elig && (!p_if_elig || !last_data);
                check_eq("grant_addr", mem_addr, win_data ? p_dm_addr : p_if_addr);
                check_eq("grant_we",   mem_we,   win_data ? p_dm_wr : 1'b0);
                if (win_data && p_dm_wr)
                    check_eq("grant_wdata", mem_wdata, p_dm_wdata);
                last_data  = win_data;
                owner_data = win_data;
                killed     = 0;
            end

            exp_if_valid = 0;
            exp_dm_valid = 0;
            if (mem_req && !owner_data && flush) killed = 1;
            if (mem_req && mem_ready) begin
                if (owner_data) begin
                    exp_dm_valid = 1;
                    if (!mem_we) exp_dm_data = mem_rdata;
                    else         mem_arr[widx(mem_addr)] = mem_wdata;
                end else begin
                    exp_if_valid = !killed;
                    exp_if_data  = mem_rdata;
                end
            end

            p_mem_req   = mem_req;
            p_mem_ready = mem_ready;
            p_mem_addr  = mem_addr;
            p_mem_we    = mem_we;
            p_mem_wdata = mem_wdata;
            p_if_elig   = if_req & ~if_valid;
            p_dm_elig   = (dm_rd | dm_wr) & ~dm_valid;
            p_if_addr   = if_addr;
            p_dm_addr   = dm_addr;
            p_dm_wr     = dm_wr;
            p_dm_wdata  = dm_wdata;
            p_if_valid  = if_valid;
            p_dm_valid  = dm_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release requests only after their valid pulse, as the stages would.
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            flush = 1'b0;
            if (p_if_valid) if_req = 1'b0;
            if (p_dm_valid) begin dm_rd = 1'b0; dm_wr = 1'b0; end
            if (!if_req && !dm_rd && !dm_wr) break;
            step();
        end
        check_eq("drain_done", {if_req, dm_rd, dm_wr}, 3'b000);
        step();
        step();
    endtask

    int          nf, nd, cnt;
    bit          got;
    logic [31:0] keep;

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0; flush = 0;
        dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;

        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(); step();

        // fetch only, zero wait states
        wait_fix = 0;
        if_req = 1; if_addr = 32'h100;
        #3 check_eq("t1_stall_c0", stall_if, 1'b1);
        step();
        #3;
        check_eq("t1_req_c1",   mem_req,  1'b1);
        check_eq("t1_addr_c1",  mem_addr, 32'h100);
        check_eq("t1_we_c1",    mem_we,   1'b0);
        check_eq("t1_stall_c1", stall_if, 1'b1);
        step();
        #3;
        check_eq("t1_valid_c2", if_valid, 1'b1);
        check_eq("t1_rdata_c2", if_rdata, mem_arr[widx(32'h100)]);
        check_eq("t1_stall_c2", stall_if, 1'b0);
        step();
        if_req = 0;
        step(); step();

        // simultaneous fetch and load, last grant was a fetch
        if_req = 1; if_addr = 32'h104;
        dm_rd  = 1; dm_addr = 32'h2000;
        step();
        #3;
        check_eq("t2_first_addr", mem_addr, 32'h2000);
        check_eq("t2_first_we",   mem_we,   1'b0);
        nf = 0; nd = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (if_valid) nf++;
            if (dm_valid) nd++;
            if (p_if_valid) if_addr = if_addr + 4;
            if (p_dm_valid) dm_addr = dm_addr + 4;
        end
        check_eq("t2_alternate", (nf == nd) || (nf == nd + 1) || (nd == nf + 1), 1'b1);
        check_eq("t2_progress",  (nf > 3) && (nd > 3), 1'b1);
        drain();

        // store with three wait states
        wait_fix = 3;
        keep = dm_rdata;
        dm_wr = 1; dm_addr = 32'h48; dm_wdata = 32'hDEADBEEF;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dm_valid) cnt++;
            if (p_dm_valid) dm_wr = 0;
        end
        check_eq("t3_pulses", cnt, 1);
        check_eq("t3_rdata_kept", dm_rdata, keep);
        check_eq("t3_mem_written", mem_arr[widx(32'h48)], 32'hDEADBEEF);
        drain();

        // flush while a fetch waits on mem_ready
        mem_arr[widx(32'h40)] = 32'h1111_0040;
        mem_arr[widx(32'h80)] = 32'h2222_0080;
        if_req = 1; if_addr = 32'h40;
        step(); step();
        flush = 1; if_addr = 32'h80;
        step();
        flush = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if_valid) begin
                got = 1;
                check_eq("t4_new_pc_data", if_rdata, 32'h2222_0080);
                break;
            end
        end
        check_eq("t4_valid_seen", got, 1'b1);
        step();
        drain();

        // reset in the middle of a data transaction
        wait_fix = 6;
        dm_rd = 1; dm_addr = 32'h2004;
        step(); step();
        #2;
        check_eq("t5_busy", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("t5_req_async",   mem_req,  1'b0);
        check_eq("t5_dmv_async",   dm_valid, 1'b0);
        check_eq("t5_ifv_async",   if_valid, 1'b0);
        wait_fix = 1;
        step();
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dm_valid) begin
                got = 1;
                check_eq("t5_load_data", dm_rdata, mem_arr[widx(32'h2004)]);
                break;
            end
        end
        check_eq("t5_valid_seen", got, 1'b1);
        step();
        drain();

        // randomized traffic
        wait_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            step();
            flush = 1'b0;
            if (!if_req || p_if_valid) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = rand_addr();
            end else if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                if_addr = rand_addr();
            end
            if (!(dm_rd || dm_wr) || p_dm_valid) begin
                dm_rd = 0; dm_wr = 0;
                if ($urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 1) == 1) dm_wr = 1;
                    else                           dm_rd = 1;
                    dm_addr  = rand_addr();
                    dm_wdata = $urandom;
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
